// File: rtl/ra_sdr_cmd_seq_32x32.sv
`default_nettype none
// ============================================================================
// Module      : ra_sdr_cmd_seq_32x32
// Description : Command sequencer for a 32x32 array (one write port, two read
//               ports) with in-order tagged read responses through a FIFO.
//               Optional read-after-write stall: RA_CMDSEQ_RAW_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ra_sdr_cmd_seq_32x32 #(
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_tag,
    output logic        rd_enb_0,
    output logic [4:0]  rd_adr_0,
    output logic        rd_enb_1,
    output logic [4:0]  rd_adr_1,
    output logic        wr_enb_0,
    output logic [4:0]  wr_adr_0,
    output logic [31:0] wr_dat_0,
    input  logic [31:0] rd_dat_0,
    input  logic [31:0] rd_dat_1,
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [3:0]  rsp_tag,
    output logic [31:0] rsp_dat,
    output logic        err,
    output logic        idle
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [1:0]         c_op_wr  = 2'b00;
    localparam logic [1:0]         c_op_rd0 = 2'b01;
    localparam logic [1:0]         c_op_rd1 = 2'b10;
    localparam logic [1:0]         c_op_nop = 2'b11;

    logic               r_rd_enb_0, r_rd_enb_1, r_wr_enb_0;
    logic [4:0]         r_rd_adr_0, r_rd_adr_1, r_wr_adr_0;
    logic [31:0]        r_wr_dat_0;
    logic [3:0]         r_iss_tag;
    logic               r_err;
    logic               r_pipe_vld  [RD_LAT];
    logic               r_pipe_port [RD_LAT];
    logic [3:0]         r_pipe_tag  [RD_LAT];
    logic [3:0]         r_fifo_tag  [DEPTH];
    logic [31:0]        r_fifo_dat  [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0] r_count, r_credit;

    logic        w_is_rd, w_raw_stall, w_cmd_rdy, w_accept, w_acc_rd;
    logic        w_rsp_val, w_pop, w_push;
    logic [31:0] w_push_dat;

    assign w_is_rd = (cmd_op == c_op_rd0) || (cmd_op == c_op_rd1);

`ifdef RA_CMDSEQ_RAW_STALL_EN
    // The write on the array port this cycle was accepted last cycle.
    assign w_raw_stall = r_wr_enb_0 && w_is_rd && (cmd_adr == r_wr_adr_0);
`else
    assign w_raw_stall = 1'b0;
`endif

    // Credit is registered, so a same-cycle pop cannot free a slot for a new read.
    assign w_cmd_rdy  = reset && (r_credit != c_depth) && !w_raw_stall;
    assign w_accept   = cmd_val && w_cmd_rdy;
    assign w_acc_rd   = w_accept && w_is_rd;
    assign w_rsp_val  = (r_count != '0);
    assign w_pop      = w_rsp_val && rsp_rdy;
    assign w_push     = r_pipe_vld[RD_LAT-1];
    assign w_push_dat = r_pipe_port[RD_LAT-1] ? rd_dat_1 : rd_dat_0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_enb_0 <= 1'b0;
            r_rd_enb_1 <= 1'b0;
            r_wr_enb_0 <= 1'b0;
            r_rd_adr_0 <= '0;
            r_rd_adr_1 <= '0;
            r_wr_adr_0 <= '0;
            r_wr_dat_0 <= '0;
            r_iss_tag  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_enb_0 <= w_accept && (cmd_op == c_op_rd0);
            r_rd_enb_1 <= w_accept && (cmd_op == c_op_rd1);
            r_wr_enb_0 <= w_accept && (cmd_op == c_op_wr);
            if (w_accept && (cmd_op == c_op_rd0)) r_rd_adr_0 <= cmd_adr;
            if (w_accept && (cmd_op == c_op_rd1)) r_rd_adr_1 <= cmd_adr;
            if (w_accept && (cmd_op == c_op_wr)) begin
                r_wr_adr_0 <= cmd_adr;
                r_wr_dat_0 <= cmd_dat;
            end
            if (w_acc_rd) r_iss_tag <= cmd_tag;
            if (w_accept && (cmd_op == c_op_nop)) r_err <= 1'b1;
        end
    end

    // Read tracking pipeline: the last stage lines up with valid array data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_port[i] <= 1'b0;
                r_pipe_tag[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= r_rd_enb_0 || r_rd_enb_1;
            r_pipe_port[0] <= r_rd_enb_1;
            r_pipe_tag[0]  <= r_iss_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_port[i] <= r_pipe_port[i-1];
                r_pipe_tag[i]  <= r_pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_tag[r_wr_ptr] <= r_pipe_tag[RD_LAT-1];
            r_fifo_dat[r_wr_ptr] <= w_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            case ({w_acc_rd, w_pop})
                2'b10:   r_credit <= r_credit + c_cnt_w'(1);
                2'b01:   r_credit <= r_credit - c_cnt_w'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign cmd_rdy  = w_cmd_rdy;
    assign rd_enb_0 = r_rd_enb_0;
    assign rd_adr_0 = r_rd_adr_0;
    assign rd_enb_1 = r_rd_enb_1;
    assign rd_adr_1 = r_rd_adr_1;
    assign wr_enb_0 = r_wr_enb_0;
    assign wr_adr_0 = r_wr_adr_0;
    assign wr_dat_0 = r_wr_dat_0;
    assign rsp_val  = w_rsp_val;
    assign rsp_tag  = w_rsp_val ? r_fifo_tag[r_rd_ptr] : '0;
    assign rsp_dat  = w_rsp_val ? r_fifo_dat[r_rd_ptr] : '0;
    assign err      = r_err;
    // Zero credit already implies no reads in the issue register, pipeline or FIFO.
    assign idle     = (r_credit == '0) && !r_rd_enb_0 && !r_rd_enb_1 && !r_wr_enb_0;

endmodule
`default_nettype wire

// File: tb/tb_ra_sdr_cmd_seq_32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_ra_sdr_cmd_seq_32x32
// Description : Self-checking bench for ra_sdr_cmd_seq_32x32 with an array
//               model and a queue-based response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ra_sdr_cmd_seq_32x32;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_tag = '0;
    logic        rd_enb_0, rd_enb_1, wr_enb_0;
    logic [4:0]  rd_adr_0, rd_adr_1, wr_adr_0;
    logic [31:0] wr_dat_0, rd_dat_0, rd_dat_1;
    logic        rsp_val;
    logic        rsp_rdy = 1'b1;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_dat;
    logic        err, idle;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int tcyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    ra_sdr_cmd_seq_32x32 #(.RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_tag(cmd_tag),
        .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1),
        .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0),
        .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_tag(rsp_tag), .rsp_dat(rsp_dat),
        .err(err), .idle(idle)
    );

    // Array model: data captured at the enable edge, presented RD_LAT cycles after enable.
    logic [31:0] arr_mem [32];
    logic [32:0] ap0 [RD_LAT];
    logic [32:0] ap1 [RD_LAT];
    always @(posedge clk) begin
        if (wr_enb_0 === 1'b1) arr_mem[wr_adr_0] <= wr_dat_0;
        ap0[0] <= {rd_enb_0 === 1'b1, arr_mem[rd_adr_0]};
        ap1[0] <= {rd_enb_1 === 1'b1, arr_mem[rd_adr_1]};
        for (int i = 1; i < RD_LAT; i++) begin
            ap0[i] <= ap0[i-1];
            ap1[i] <= ap1[i-1];
        end
    end
    assign rd_dat_0 = ap0[RD_LAT-1][32] ? ap0[RD_LAT-1][31:0] : 32'hBADBAD00;
    assign rd_dat_1 = ap1[RD_LAT-1][32] ? ap1[RD_LAT-1][31:0] : 32'hBADBAD11;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    // Response model: outstanding reads in acceptance order, each with its earliest valid cycle.
    typedef struct {
        int          rdy;
        logic [3:0]  tag;
        logic [31:0] dat;
    } rsp_t;
    rsp_t        m_q [$];
    logic [31:0] m_mem [32];
    logic        m_en_r0 = 0, m_en_r1 = 0, m_en_wr = 0, m_err = 0, m_rst = 1;
    logic [4:0]  m_adr_r0 = 0, m_adr_r1 = 0, m_adr_wr = 0;
    logic [31:0] m_dat_wr = 0;
    logic        e_raw, e_rdy, e_val, e_idle, e_acc, e_pop;

    always @(negedge clk) begin
        e_raw = 1'b0;
`ifdef RA_CMDSEQ_RAW_STALL_EN
        e_raw = m_en_wr && (cmd_op == 2'b01 || cmd_op == 2'b10) && (cmd_adr == m_adr_wr);
`endif
        e_rdy  = reset && (m_q.size() < DEPTH) && !e_raw;
        e_val  = (m_q.size() > 0) && (m_q[0].rdy <= tcyc);
        e_idle = (m_q.size() == 0) && !m_en_r0 && !m_en_r1 && !m_en_wr;
        chk("cmd_rdy", cmd_rdy, e_rdy);
        chk("rd_enb_0", rd_enb_0, m_en_r0);
        chk("rd_adr_0", rd_adr_0, m_adr_r0);
        chk("rd_enb_1", rd_enb_1, m_en_r1);
        chk("rd_adr_1", rd_adr_1, m_adr_r1);
        chk("wr_enb_0", wr_enb_0, m_en_wr);
        chk("wr_adr_0", wr_adr_0, m_adr_wr);
        chk("wr_dat_0", wr_dat_0, m_dat_wr);
        chk("rsp_val", rsp_val, e_val);
        chk("err", err, m_err);
        chk("idle", idle, e_idle);
        if (e_val) begin
            chk("rsp_tag", rsp_tag, m_q[0].tag);
            chk("rsp_dat", rsp_dat, m_q[0].dat);
        end else if (m_rst) begin
            chk("rsp_tag_rst", rsp_tag, 0);
            chk("rsp_dat_rst", rsp_dat, 0);
        end
        if (!reset) begin
            m_q.delete();
            m_en_r0 = 0; m_en_r1 = 0; m_en_wr = 0; m_err = 0; m_rst = 1;
            m_adr_r0 = 0; m_adr_r1 = 0; m_adr_wr = 0; m_dat_wr = 0;
        end else begin
            m_rst = 0;
            e_acc = cmd_val && e_rdy;
            e_pop = e_val && rsp_rdy;
            if (e_pop) void'(m_q.pop_front());
            m_en_r0 = 0; m_en_r1 = 0; m_en_wr = 0;
            if (e_acc) begin
                case (cmd_op)
                    2'b00: begin
                        m_mem[cmd_adr] = cmd_dat;
                        m_en_wr = 1; m_adr_wr = cmd_adr; m_dat_wr = cmd_dat;
                    end
                    2'b01: begin
                        m_q.push_back('{tcyc + RD_LAT + 2, cmd_tag, m_mem[cmd_adr]});
                        m_en_r0 = 1; m_adr_r0 = cmd_adr;
                    end
                    2'b10: begin
                        m_q.push_back('{tcyc + RD_LAT + 2, cmd_tag, m_mem[cmd_adr]});
                        m_en_r1 = 1; m_adr_r1 = cmd_adr;
                    end
                    default: m_err = 1;
                endcase
            end
        end
    end

    logic [31:0] got_tag [$];
    logic [31:0] got_dat [$];
    always @(negedge clk) begin
        if (rsp_val === 1'b1 && rsp_rdy) begin
            got_tag.push_back(32'(rsp_tag));
            got_dat.push_back(rsp_dat);
        end
    end

    function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic send(input logic [1:0] op, input logic [4:0] adr, input logic [31:0] dat,
                        input logic [3:0] tag, output int acc_cyc);
        bit done = 0;
        cmd_val = 1; cmd_op = op; cmd_adr = adr; cmd_dat = dat; cmd_tag = tag;
        acc_cyc = -1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin
                done = 1;
                acc_cyc = tcyc;
            end
            @(posedge clk);
            #1;
        end
        cmd_val = 0; cmd_op = 2'b00;
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: op %b adr %0d got no accept required accept", op, adr);
        end else begin
            n_acc++;
        end
    endtask

    task automatic wait_rsp(output int c);
        bit seen = 0;
        c = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (rsp_val === 1'b1) begin
                seen = 1;
                c = tcyc;
            end
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL rsp_timeout: got no rsp_val required rsp_val");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    int a_wr, a_rd, c_rsp, tmp_a, g0, g1, g2, g3;

    initial begin
        for (int i = 0; i < 32; i++) begin
            arr_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
            m_mem[i]   = 32'h1000_0000 + 32'(i) * 32'h111;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            ap0[i] = '0;
            ap1[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", idle, 1);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_adr", wr_adr_0, 0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("rdy_after_rst", cmd_rdy, 1);
        @(posedge clk); #1;

        // Write then read back through port 0
        send(2'b00, 5'd5, 32'hDEADBEEF, 4'd0, a_wr);
        chk("wr_pulse_on", wr_enb_0, 1);
        chk("wr_pulse_adr", wr_adr_0, 5);
        send(2'b01, 5'd5, 32'h0, 4'd3, a_rd);
        chk("wr_pulse_off", wr_enb_0, 0);
        chk("rd0_issue", rd_enb_0, 1);
        chk("rd0_adr", rd_adr_0, 5);
        wait_rsp(c_rsp);
        chk("rsp_latency", 32'(c_rsp - a_rd), 4);
        chk("rsp_tag_3", rsp_tag, 4'd3);
        chk("rsp_dat_beef", rsp_dat, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Write then read of the same address, back to back
        send(2'b00, 5'd7, 32'h0000_7777, 4'd0, a_wr);
        send(2'b10, 5'd7, 32'h0, 4'd1, a_rd);
`ifdef RA_CMDSEQ_RAW_STALL_EN
        chk("raw_gap", 32'(a_rd - a_wr), 2);
`else
        chk("raw_gap", 32'(a_rd - a_wr), 1);
`endif
        wait_rsp(c_rsp);
        chk("raw_rsp_dat", rsp_dat, 32'h0000_7777);
        @(posedge clk); #1;

        // Fill the response FIFO with rsp_rdy low
        rsp_rdy = 0;
        g0 = got_tag.size();
        g1 = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'b01, 5'(10 + i), 32'h0, 4'(i), tmp_a);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("fill_accepts", 32'(n_acc - g1), 4);
                chk("fill_cmd_rdy", cmd_rdy, 0);
                rsp_rdy = 1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) chk("fill_order", qget(got_tag, g0 + i), 32'(i));
        chk("fill_dat0", qget(got_dat, g0), 32'h1000_0AAA);

        // Alternating read ports
        g1 = got_tag.size();
        send(2'b01, 5'd1, 32'h0, 4'd4, tmp_a);
        send(2'b10, 5'd2, 32'h0, 4'd5, tmp_a);
        send(2'b01, 5'd1, 32'h0, 4'd6, tmp_a);
        send(2'b10, 5'd2, 32'h0, 4'd7, tmp_a);
        repeat (10) @(posedge clk);
        #1;
        chk("alt_count", 32'(got_tag.size() - g1), 4);
        chk("alt_dat_p0", qget(got_dat, g1), 32'h1000_0111);
        chk("alt_dat_p1", qget(got_dat, g1 + 1), 32'h1000_0222);
        chk("alt_tag_last", qget(got_tag, g1 + 3), 7);

        // Reserved op
        g2 = got_tag.size();
        send(2'b11, 5'd9, 32'h0, 4'd9, tmp_a);
        repeat (8) @(posedge clk);
        #1;
        chk("nop_err", err, 1);
        chk("nop_no_rsp", 32'(got_tag.size() - g2), 0);

        // Reset with reads in flight and one queued response
        rsp_rdy = 0;
        send(2'b01, 5'd3, 32'h0, 4'd10, tmp_a);
        send(2'b10, 5'd4, 32'h0, 4'd11, tmp_a);
        send(2'b01, 5'd5, 32'h0, 4'd12, tmp_a);
        repeat (RD_LAT - 1) @(posedge clk);
        #1;
        chk("pre_rst_rsp_val", rsp_val, 1);
        chk("pre_rst_idle", idle, 0);
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        g3 = got_tag.size();
        rsp_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_val", rsp_val, 0);
            chk("post_rst_idle", idle, 1);
            chk("post_rst_cmd_rdy", cmd_rdy, 1);
        end
        chk("post_rst_err", err, 0);
        chk("post_rst_no_rsp", 32'(got_tag.size() - g3), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
